// File: rtl/schoolbook_pkg.sv
// Shared constants and state type for the 224x224 schoolbook multiplier and its unload path.
package schoolbook_pkg;

  localparam int PW     = 448;
  localparam int OW     = 32;
  localparam int NWORDS = PW / OW;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/product_serializer.sv
// Captures one PW-bit product via valid/ready and streams it out as OW-bit words, LSW first.
// One idle bubble separates products; in_ready depends on state only.
module product_serializer #(
  parameter int PW = schoolbook_pkg::PW,
  parameter int OW = schoolbook_pkg::OW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);
  import schoolbook_pkg::*;

  localparam int NWORDS_P = PW / OW;
  localparam int IDX_W    = (NWORDS_P > 1) ? $clog2(NWORDS_P) : 1;

  generate
    if ((PW % OW) != 0) begin : g_bad_width
      $error("product_serializer: PW must be a multiple of OW");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_next;
  logic [PW-1:0]     r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic              w_last;
  logic              w_accept;
  logic              w_fire;

  assign w_last   = (r_idx == IDX_W'(NWORDS_P - 1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_fire   = (r_state == SEND) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = SEND;
      SEND:    if (out_ready && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = (r_state == SEND);
    out_last  = (r_state == SEND) && w_last;
    out_data  = (r_state == SEND) ? r_buf[OW-1:0] : '0;
  end

  // Buffer shifts down one word per handshake so the current word always sits at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_buf <= in_data;
      r_idx <= '0;
    end else if (w_fire) begin
      r_buf <= r_buf >> OW;
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_product_serializer.sv
module tb_product_serializer;
  import schoolbook_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic [PW-1:0] data;
    int            mode;      // 0: ready always, 1: ready pattern, 2: random ready
    logic [3:0]    pat;
    logic [OW-1:0] exp_first;
    logic [OW-1:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: word k of a product is simply the product divided down by 2^(OW*k).
  function automatic logic [OW-1:0] model_word(input logic [PW-1:0] p, input int k);
    logic [PW-1:0] s;
    s = p >> (OW * k);
    return s[OW-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_product();
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < NWORDS; k++) p = (p << OW) | PW'($urandom);
    return p;
  endfunction

  task automatic offer(input logic [PW-1:0] p);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = p;
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_during_send", in_ready, 0);
    $display("accept product %0h", p);
  endtask

  task automatic drain(input logic [PW-1:0] p, input int mode, input logic [3:0] pat,
                       output logic [OW-1:0] first, output logic [OW-1:0] lastw);
    int k     = 0;
    int cyc   = 0;
    int lasts = 0;
    first = '0;
    lastw = '0;
    while (k < NWORDS && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      chk($sformatf("out_valid_w%0d", k), out_valid, 1);
      chk($sformatf("word%0d", k), out_data, model_word(p, k));
      chk($sformatf("out_last_w%0d", k), out_last, (k == NWORDS - 1));
      if (out_ready) begin
        if (k == 0) first = out_data;
        if (out_last) begin
          lasts++;
          lastw = out_data;
        end
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("handshakes", k, NWORDS);
    chk("last_count", lasts, 1);
    chk("out_valid_bubble", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_back", busy, 0);
    $display("drained %0d words in %0d cycles", k, cyc);
  endtask

  vec_t          vecs[4];
  logic [PW-1:0] cnt_pat;
  logic [PW-1:0] p_a;
  logic [PW-1:0] p_b;
  logic [OW-1:0] f_w;
  logic [OW-1:0] l_w;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    cnt_pat = '0;
    for (int k = 0; k < NWORDS; k++) cnt_pat[OW*k +: OW] = OW'(k + 1);

    vecs[0] = '{data: cnt_pat, mode: 0, pat: 4'b1111, exp_first: 32'h1,        exp_last: 32'hE};
    vecs[1] = '{data: '1,      mode: 1, pat: 4'b1001, exp_first: 32'hFFFFFFFF, exp_last: 32'hFFFFFFFF};
    vecs[2] = '{data: '0,      mode: 0, pat: 4'b1111, exp_first: 32'h0,        exp_last: 32'h0};
    vecs[3] = '{data: cnt_pat, mode: 2, pat: 4'b0000, exp_first: 32'h1,        exp_last: 32'hE};

    // Reset state
    #13;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven products
    for (int i = 0; i < 4; i++) begin
      offer(vecs[i].data);
      in_valid = 1'b0;
      in_data  = rand_product();
      drain(vecs[i].data, vecs[i].mode, vecs[i].pat, f_w, l_w);
      chk($sformatf("vec%0d_first", i), f_w, vecs[i].exp_first);
      chk($sformatf("vec%0d_last", i), l_w, vecs[i].exp_last);
    end

    // Random products with random backpressure
    for (int i = 0; i < 8; i++) begin
      p_a = rand_product();
      offer(p_a);
      in_valid = 1'b0;
      in_data  = rand_product();
      drain(p_a, 2, 4'b0000, f_w, l_w);
      chk("rand_first", f_w, model_word(p_a, 0));
      chk("rand_last", l_w, model_word(p_a, NWORDS - 1));
    end

    // Back-to-back: in_valid held, in_data switched to B during SEND of A
    p_a = rand_product();
    p_b = rand_product();
    offer(p_a);
    in_data = p_b;
    drain(p_a, 0, 4'b1111, f_w, l_w);
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1);
    chk("b2b_word0", out_data, model_word(p_b, 0));
    in_valid = 1'b0;
    drain(p_b, 0, 4'b1111, f_w, l_w);

    // Reset after 5 words accepted
    p_a = rand_product();
    offer(p_a);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("pre_rst_word%0d", j), out_data, model_word(p_a, j));
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    p_b = rand_product();
    offer(p_b);
    in_valid = 1'b0;
    drain(p_b, 2, 4'b0000, f_w, l_w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
